// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider.
// Divides a 2W-bit dividend by a W-bit divisor and produces one quotient bit per clock.
// A start/done handshake frames each operation.
// The quotient and remainder registers hold the last completed result until the next one is ready.
module seq_restoring_divider #(
  parameter int W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*W-1:0]   dividend,
  input  logic [W-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   quotient,
  output logic [W-1:0]     remainder,
  output logic             div_zero
);

  localparam int QW    = 2 * W;
  localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QW - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    dvd_q, dvd_d;         // dividend, shifted left one bit per step
  logic [W-1:0]     dsr_q, dsr_d;         // divisor captured at accept
  logic [W:0]       rem_q, rem_d;         // partial remainder, one guard bit
  logic [QW-1:0]    q_q, q_d;             // quotient under construction
  logic [CNT_W-1:0] cnt_q, cnt_d;         // step index within the operation
  logic [QW-1:0]    quotient_q, quotient_d;
  logic [W-1:0]     remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic [W:0]       trial;
  logic             fits;
  logic [W:0]       rem_step;
  logic [QW-1:0]    q_step;
  logic             dsr_is_zero;

  // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
  // The compare is W+1 bits wide, so it cannot overflow.
  always_comb begin
    trial       = {rem_q[W-1:0], dvd_q[QW-1]};
    fits        = (trial >= {1'b0, dsr_q});
    rem_step    = fits ? (trial - {1'b0, dsr_q}) : trial;
    q_step      = {q_q[QW-2:0], fits};
    dsr_is_zero = (dsr_q == '0);
  end

  // Next-state and datapath control. The DONE state accepts start so operations can run back to back.
  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      ST_RUN: begin
        dvd_d = dvd_q << 1;
        rem_d = rem_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          // With a zero divisor the raw algorithm yields all-ones and the
          // dividend's low bits; report a clean all-ones / zero instead.
          if (dsr_is_zero) begin
            quotient_d  = '1;
            remainder_d = '0;
            div_zero_d  = 1'b1;
          end else begin
            quotient_d  = q_step;
            remainder_d = rem_step[W-1:0];
            div_zero_d  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
      default: begin
        state_d = start ? ST_RUN : ST_IDLE;
      end
    endcase

    // Accept: capture operands, start a fresh iteration. The previous
    // quotient/remainder stay visible until this operation completes.
    if (start && (state_q != ST_RUN)) begin
      dvd_d      = dividend;
      dsr_d      = divisor;
      rem_d      = '0;
      q_d        = '0;
      cnt_d      = '0;
      div_zero_d = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (W=2).
// Accepted requests push an expected result with its completion time.
// A negedge monitor checks busy/done every cycle.
// It also checks the result outputs, which must hold between completions.
module tb_seq_restoring_divider;

  localparam int W  = 2;
  localparam int QW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [QW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [QW-1:0] quotient;
  logic [W-1:0]  remainder;
  logic          div_zero;

  seq_restoring_divider #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned dvd;
    int unsigned dsr;
    int unsigned done_at;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;
  int unsigned free_at  = 0;
  int unsigned acc_cnt  = 0;
  int unsigned last_q   = 0;
  int unsigned last_r   = 0;
  int unsigned dz_exp   = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Behavioural timing model: an operation occupies the divider for 2W cycles
  // after it is accepted; a request is taken whenever the divider is free,
  // including the cycle in which the previous result is presented.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      free_at = 0;
      last_q  = 0;
      last_r  = 0;
      dz_exp  = 0;
    end else begin
      cyc++;
      if (start === 1'b1 && cyc >= free_at) begin
        sb.push_back('{dvd: dividend, dsr: divisor, done_at: cyc + QW});
        free_at = cyc + QW + 1;
        dz_exp  = 0;
        acc_cnt++;
      end
    end
  end

  // Monitor: compare handshake and result outputs against the scoreboard.
  exp_t        cur;
  logic        exp_done;
  logic        exp_busy;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      exp_done = (sb.size() > 0) && (sb[0].done_at == cyc);
      exp_busy = (sb.size() > 0) && (cyc < sb[0].done_at);
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (exp_done) begin
        cur = sb.pop_front();
        if (cur.dsr == 0) begin
          last_q = (1 << QW) - 1;
          last_r = 0;
          dz_exp = 1;
        end else begin
          last_q = cur.dvd / cur.dsr;
          last_r = cur.dvd % cur.dsr;
          dz_exp = 0;
          chk("identity", quotient * cur.dsr + remainder, cur.dvd);
          chk("rem_lt_dsr", (remainder < cur.dsr) ? 1 : 0, 1);
        end
      end
      chk("quotient", quotient, last_q);
      chk("remainder", remainder, last_r);
      chk("div_zero", div_zero, dz_exp);
    end
  end

  // Request an operation and keep start high until it is accepted.
  task automatic op(input int unsigned a, input int unsigned b);
    int unsigned a0;
    bit          ok;
    @(negedge clk);
    a0       = acc_cnt;
    dividend = QW'(a);
    divisor  = W'(b);
    start    = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != a0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: request %0d/%0d not accepted within 40 cycles", a, b);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    bit ok;
    start = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_div_zero", div_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, including divide by zero and its clearing.
    op(9, 2);   idle(6);
    op(15, 3);  idle(6);
    op(2, 3);   idle(6);
    op(6, 0);   idle(6);
    op(7, 1);   idle(6);

    // Start held high: second request must wait for the DONE cycle.
    op(12, 3);
    op(13, 2);
    idle(7);

    // Reset during the second RUN cycle aborts the operation.
    op(14, 3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_div_zero", div_zero, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    op(14, 3);  idle(6);

    // Exhaustive sweep, back to back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 4; b++) begin
        op(a, b);
      end
    end
    idle(6);

    // Random traffic with random gaps.
    for (int n = 0; n < 150; n++) begin
      op($urandom_range(0, 15), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
    end

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
